// File: rtl/versatile_mem_ctrl_ddr_seq_pkg.sv
// Shared constants and helpers for the DDR2 burst data-phase sequencer.
// Schedule offsets are counted in clk_0 cycles from the command accept cycle.
package versatile_mem_ctrl_ddr_seq_pkg;

    localparam int DEF_CL      = 3;
    localparam int DEF_BL      = 4;
    localparam int DEF_RX_PIPE = 2;

    // Each direction carries three parallel schedules; lane 0 is always DQ-pin occupancy.
    localparam int NLANE     = 3;
    localparam int LANE_OCC  = 0;
    localparam int LANE_AUX0 = 1;
    localparam int LANE_AUX1 = 2;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_e;

    function automatic int burst_cycles(input int bl);
        return bl / 2;
    endfunction

    function automatic int write_latency(input int cl);
        return cl - 1;
    endfunction

    function automatic int sched_len(input int cl, input int bl, input int rx_pipe);
        return cl + rx_pipe + (bl / 2);
    endfunction

    function automatic logic in_win(input int k, input int lo, input int hi);
        return (k >= lo) && (k <= hi);
    endfunction

endpackage

// File: rtl/versatile_mem_ctrl_ddr_seq_window.sv
// One direction of the sequencer: NLANE shift-register schedules with a load mask,
// plus the DQ-window conflict check against candidate commands of either direction.
module versatile_mem_ctrl_ddr_seq_window
    import versatile_mem_ctrl_ddr_seq_pkg::*;
#(
    parameter int L        = 7,
    parameter bit OPP_PRE  = 1'b0,
    parameter bit OPP_POST = 1'b0
) (
    input  logic               clk_0,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [NLANE*L-1:0] i_mask,
    input  logic [L-1:0]       i_cand_same,
    input  logic [L-1:0]       i_cand_opp,
    output logic               o_hit_same,
    output logic               o_hit_opp,
    output logic [NLANE-1:0]   o_head,
    output logic               o_busy
);

    logic [NLANE-1:0][L-1:0] r_sched;
    logic [NLANE-1:0][L-1:0] w_next;
    logic                    r_busy;
    logic [L-1:0]            w_occ;
    logic [L-1:0]            w_guard;

    // Bit k of a schedule is activity k cycles from now; a mask bit k is k cycles from the accept cycle.
    always_comb begin
        for (int n = 0; n < NLANE; n++) begin
            w_next[n] = r_sched[n] >> 1;
            if (i_load) begin
                w_next[n] = w_next[n] | (i_mask[n*L +: L] >> 1);
            end
        end
    end

    always_ff @(posedge clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            r_sched <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_sched <= w_next;
            r_busy  <= |w_next;
        end
    end

    assign w_occ = r_sched[LANE_OCC];

    // Turnaround guard: widen the pending window by one cycle on the side where the
    // opposite direction must leave the bus idle.
    assign w_guard = w_occ
                   | (OPP_PRE  ? (w_occ >> 1) : '0)
                   | (OPP_POST ? (w_occ << 1) : '0);

    assign o_hit_same = |(i_cand_same & w_occ);
    assign o_hit_opp  = |(i_cand_opp & w_guard);
    assign o_busy     = r_busy;

    for (genvar n = 0; n < NLANE; n++) begin : g_head
        assign o_head[n] = r_sched[n][0];
    end

endmodule

// File: rtl/versatile_mem_ctrl_ddr_seq.sv
// DDR2 burst data-phase sequencer: builds per-command schedule masks from CL/BL, accepts or refuses
// column commands, and drives FIFO strobes and PHY enables. Optional DQS preamble: DDR_SEQ_PREAMBLE_EN.
module versatile_mem_ctrl_ddr_seq
    import versatile_mem_ctrl_ddr_seq_pkg::*;
#(
    parameter int CL      = DEF_CL,
    parameter int BL      = DEF_BL,
    parameter int RX_PIPE = DEF_RX_PIPE
) (
    input  logic clk_0,
    input  logic rst_n,
    input  logic col_valid_i,
    input  logic col_we_i,
    input  logic col_full_i,
    output logic col_ready_o,
    output logic tx_pop_o,
    output logic dq_en,
    output logic dqm_en,
    output logic rx_push_o,
    output logic rx_last_o,
    output logic busy_o,
    output logic err_o
);

    localparam int BC = burst_cycles(BL);
    localparam int WL = write_latency(CL);
    localparam int L  = sched_len(CL, BL, RX_PIPE);

`ifdef DDR_SEQ_PREAMBLE_EN
    localparam int WR_OCC_LO = WL - 1;
`else
    localparam int WR_OCC_LO = WL;
`endif

    logic [L-1:0]     w_wr_data;
    logic [L-1:0]     w_wr_occ;
    logic [L-1:0]     w_wr_pop;
    logic [L-1:0]     w_rd_occ;
    logic [L-1:0]     w_rd_push;
    logic [L-1:0]     w_rd_last;
    logic [NLANE-1:0] w_wr_head;
    logic [NLANE-1:0] w_rd_head;
    logic             w_wr_hit_same;
    logic             w_wr_hit_opp;
    logic             w_rd_hit_same;
    logic             w_rd_hit_opp;
    logic             w_wr_busy;
    logic             w_rd_busy;
    logic             w_ready;
    logic             w_accept;
    logic             w_unused_rd_pins;
    dir_e             w_dir;

    for (genvar k = 0; k < L; k++) begin : g_mask
        assign w_wr_data[k] = in_win(k, WL, WL + BC - 1);
        assign w_wr_occ[k]  = in_win(k, WR_OCC_LO, WL + BC - 1);
        assign w_wr_pop[k]  = in_win(k, WL - 1, WL + BC - 2);
        assign w_rd_occ[k]  = in_win(k, CL, CL + BC - 1);
        assign w_rd_push[k] = in_win(k, CL + RX_PIPE, L - 1);
        assign w_rd_last[k] = (k == L - 1);
    end

    // Same-direction writes are checked on data cycles only, so an abutting write's last
    // beat can stand in for the next write's preamble.
    versatile_mem_ctrl_ddr_seq_window #(
        .L        (L),
        .OPP_PRE  (1'b0),
        .OPP_POST (1'b1)
    ) u_wr (
        .clk_0       (clk_0),
        .rst_n       (rst_n),
        .i_load      (w_accept && (w_dir == DIR_WR)),
        .i_mask      ({w_wr_data & {L{col_full_i}}, w_wr_pop, w_wr_occ}),
        .i_cand_same (w_wr_data),
        .i_cand_opp  (w_rd_occ),
        .o_hit_same  (w_wr_hit_same),
        .o_hit_opp   (w_wr_hit_opp),
        .o_head      (w_wr_head),
        .o_busy      (w_wr_busy)
    );

    // A write landing right before a pending read needs an idle cycle; a write may follow a read directly.
    versatile_mem_ctrl_ddr_seq_window #(
        .L        (L),
        .OPP_PRE  (1'b1),
        .OPP_POST (1'b0)
    ) u_rd (
        .clk_0       (clk_0),
        .rst_n       (rst_n),
        .i_load      (w_accept && (w_dir == DIR_RD)),
        .i_mask      ({w_rd_last, w_rd_push, w_rd_occ}),
        .i_cand_same (w_rd_occ),
        .i_cand_opp  (w_wr_occ),
        .o_hit_same  (w_rd_hit_same),
        .o_hit_opp   (w_rd_hit_opp),
        .o_head      (w_rd_head),
        .o_busy      (w_rd_busy)
    );

    assign w_dir = dir_e'(col_we_i);

    always_comb begin
        w_ready = 1'b1;
        case (w_dir)
            DIR_WR:  w_ready = !(w_wr_hit_same || w_rd_hit_opp);
            default: w_ready = !(w_rd_hit_same || w_wr_hit_opp);
        endcase
    end

    assign w_accept    = col_valid_i && w_ready;
    assign col_ready_o = w_ready;
    assign err_o       = col_valid_i && !w_ready;

    assign tx_pop_o  = w_wr_head[LANE_AUX0];
    assign dq_en     = w_wr_head[LANE_OCC];
    assign dqm_en    = w_wr_head[LANE_AUX1];
    assign rx_push_o = w_rd_head[LANE_AUX0];
    assign rx_last_o = w_rd_head[LANE_AUX1];
    assign busy_o    = w_wr_busy || w_rd_busy;

    assign w_unused_rd_pins = w_rd_head[LANE_OCC];

endmodule

// File: tb/tb_versatile_mem_ctrl_ddr_seq.sv
// Bench for versatile_mem_ctrl_ddr_seq: BL=4 and BL=8 instances, per-cycle expected output
// vectors queued at stimulus time and compared as the cycles run. Honours DDR_SEQ_PREAMBLE_EN.
module tb_versatile_mem_ctrl_ddr_seq;

`ifdef DDR_SEQ_PREAMBLE_EN
    localparam int PRE = 1;
`else
    localparam int PRE = 0;
`endif

    logic clk_0       = 1'b0;
    logic rst_n       = 1'b1;
    logic col_valid_i = 1'b0;
    logic col_we_i    = 1'b0;
    logic col_full_i  = 1'b0;
    logic col_ready_o, tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o, err_o;

    logic u8_valid = 1'b0;
    logic u8_we    = 1'b0;
    logic u8_full  = 1'b0;
    logic u8_ready, u8_pop, u8_dq, u8_dqm, u8_push, u8_last, u8_busy, u8_err;

    int checks = 0;
    int errors = 0;

    always #5 clk_0 = ~clk_0;

    versatile_mem_ctrl_ddr_seq #(.CL(3), .BL(4), .RX_PIPE(2)) dut (
        .clk_0       (clk_0),
        .rst_n       (rst_n),
        .col_valid_i (col_valid_i),
        .col_we_i    (col_we_i),
        .col_full_i  (col_full_i),
        .col_ready_o (col_ready_o),
        .tx_pop_o    (tx_pop_o),
        .dq_en       (dq_en),
        .dqm_en      (dqm_en),
        .rx_push_o   (rx_push_o),
        .rx_last_o   (rx_last_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    versatile_mem_ctrl_ddr_seq #(.CL(3), .BL(8), .RX_PIPE(2)) dut8 (
        .clk_0       (clk_0),
        .rst_n       (rst_n),
        .col_valid_i (u8_valid),
        .col_we_i    (u8_we),
        .col_full_i  (u8_full),
        .col_ready_o (u8_ready),
        .tx_pop_o    (u8_pop),
        .dq_en       (u8_dq),
        .dqm_en      (u8_dqm),
        .rx_push_o   (u8_push),
        .rx_last_o   (u8_last),
        .busy_o      (u8_busy),
        .err_o       (u8_err)
    );

    function automatic logic in_r(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs got %b expected 000000", {tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o});
        end
        checks++;
        if ({col_ready_o, err_o} !== 2'b10) begin
            errors++;
            $display("FAIL reset_ready ready/err got %b expected 10", {col_ready_o, err_o});
        end
        checks++;
        if ({u8_ready, u8_pop, u8_dq, u8_dqm, u8_push, u8_last, u8_busy, u8_err} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_bl8 got %b expected 10000000", {u8_ready, u8_pop, u8_dq, u8_dqm, u8_push, u8_last, u8_busy, u8_err});
        end
        @(posedge clk_0);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_write_single();
        logic [5:0] q[$];
        logic [5:0] e;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_0); #1;
            col_valid_i = (c == 0);
            col_we_i    = 1'b1;
            col_full_i  = 1'b1;
            if (c == 0) begin
                for (int t = 0; t < 8; t++)
                    q.push_back({in_r(t, 1, 2), in_r(t, 2 - PRE, 3), in_r(t, 2, 3), 1'b0, 1'b0, in_r(t, 1, 3)});
            end
            #1;
            if (c == 0) begin
                checks++;
                if ({col_ready_o, err_o} !== 2'b10) begin
                    errors++;
                    $display("FAIL wr1_accept ready/err got %b expected 10", {col_ready_o, err_o});
                end
            end
            e = q.pop_front();
            checks++;
            if ({tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o} !== e) begin
                errors++;
                $display("FAIL wr1_c%0d pop/dq/dqm/push/last/busy got %b expected %b", c,
                         {tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o}, e);
            end
        end
        col_valid_i = 1'b0;
    endtask

    task automatic test_read_single();
        logic [5:0] q[$];
        logic [5:0] e;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk_0); #1;
            col_valid_i = (c == 0);
            col_we_i    = 1'b0;
            col_full_i  = 1'b0;
            if (c == 0) begin
                for (int t = 0; t < 9; t++)
                    q.push_back({3'b000, in_r(t, 5, 6), (t == 6), in_r(t, 1, 6)});
            end
            #1;
            if (c == 0) begin
                checks++;
                if ({col_ready_o, err_o} !== 2'b10) begin
                    errors++;
                    $display("FAIL rd1_accept ready/err got %b expected 10", {col_ready_o, err_o});
                end
            end
            e = q.pop_front();
            checks++;
            if ({tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o} !== e) begin
                errors++;
                $display("FAIL rd1_c%0d pop/dq/dqm/push/last/busy got %b expected %b", c,
                         {tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o}, e);
            end
        end
        col_valid_i = 1'b0;
    endtask

    task automatic test_back_to_back_write();
        logic [5:0] q[$];
        logic [5:0] e;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_0); #1;
            col_valid_i = (c == 0) || (c == 2);
            col_we_i    = 1'b1;
            col_full_i  = (c == 0);
            if (c == 0) begin
                for (int t = 0; t < 8; t++)
                    q.push_back({in_r(t, 1, 4), in_r(t, 2 - PRE, 5), in_r(t, 2, 3), 1'b0, 1'b0, in_r(t, 1, 5)});
            end
            #1;
            if (col_valid_i) begin
                checks++;
                if ({col_ready_o, err_o} !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_wr_accept_c%0d ready/err got %b expected 10", c, {col_ready_o, err_o});
                end
            end
            e = q.pop_front();
            checks++;
            if ({tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o} !== e) begin
                errors++;
                $display("FAIL b2b_wr_c%0d pop/dq/dqm/push/last/busy got %b expected %b", c,
                         {tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o}, e);
            end
        end
        col_valid_i = 1'b0;
    endtask

    task automatic test_back_to_back_read();
        logic [5:0] q[$];
        logic [5:0] e;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_0); #1;
            col_valid_i = (c == 0) || (c == 2);
            col_we_i    = 1'b0;
            col_full_i  = 1'b0;
            if (c == 0) begin
                for (int t = 0; t < 10; t++)
                    q.push_back({3'b000, in_r(t, 5, 8), (t == 6) || (t == 8), in_r(t, 1, 8)});
            end
            #1;
            if (col_valid_i) begin
                checks++;
                if ({col_ready_o, err_o} !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_rd_accept_c%0d ready/err got %b expected 10", c, {col_ready_o, err_o});
                end
            end
            e = q.pop_front();
            checks++;
            if ({tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o} !== e) begin
                errors++;
                $display("FAIL b2b_rd_c%0d pop/dq/dqm/push/last/busy got %b expected %b", c,
                         {tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o}, e);
            end
        end
        col_valid_i = 1'b0;
    endtask

    // WRITE at 0 (no full), READ at 1 refused (no turnaround gap), READ at 2 accepted.
    task automatic test_turnaround();
        logic [5:0] q[$];
        logic [5:0] e;
        logic       exp_rdy;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_0); #1;
            col_valid_i = (c <= 2);
            col_we_i    = (c == 0);
            col_full_i  = 1'b0;
            if (c == 0) begin
                for (int t = 0; t < 10; t++)
                    q.push_back({in_r(t, 1, 2), in_r(t, 2 - PRE, 3), 1'b0, in_r(t, 7, 8), (t == 8), in_r(t, 1, 8)});
            end
            #1;
            if (col_valid_i) begin
                exp_rdy = (c != 1);
                checks++;
                if (col_ready_o !== exp_rdy || err_o !== !exp_rdy) begin
                    errors++;
                    $display("FAIL turn_accept_c%0d ready/err got %b%b expected %b%b", c,
                             col_ready_o, err_o, exp_rdy, !exp_rdy);
                end
            end
            e = q.pop_front();
            checks++;
            if ({tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o} !== e) begin
                errors++;
                $display("FAIL turn_c%0d pop/dq/dqm/push/last/busy got %b expected %b", c,
                         {tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o}, e);
            end
        end
        col_valid_i = 1'b0;
    endtask

    // BL=8: READ at 0, WRITE requested every cycle from 3 until accepted.
    task automatic test_bl8_collision();
        logic [5:0] q[$];
        logic [5:0] e;
        logic       exp_rdy;
        int         acc = 5 + PRE;
        for (int c = 0; c < 13; c++) begin
            @(posedge clk_0); #1;
            u8_valid = (c == 0) || ((c >= 3) && (c <= acc));
            u8_we    = (c != 0);
            u8_full  = 1'b1;
            if (c == 0) begin
                for (int t = 0; t < 13; t++)
                    q.push_back({in_r(t, acc + 1, acc + 4), in_r(t, acc + 2 - PRE, acc + 5), in_r(t, acc + 2, acc + 5),
                                 in_r(t, 5, 8), (t == 8), in_r(t, 1, acc + 5)});
            end
            #1;
            if (u8_valid) begin
                exp_rdy = (c == 0) || (c == acc);
                checks++;
                if (u8_ready !== exp_rdy || u8_err !== !exp_rdy) begin
                    errors++;
                    $display("FAIL bl8_accept_c%0d ready/err got %b%b expected %b%b", c,
                             u8_ready, u8_err, exp_rdy, !exp_rdy);
                end
            end
            e = q.pop_front();
            checks++;
            if ({u8_pop, u8_dq, u8_dqm, u8_push, u8_last, u8_busy} !== e) begin
                errors++;
                $display("FAIL bl8_c%0d pop/dq/dqm/push/last/busy got %b expected %b", c,
                         {u8_pop, u8_dq, u8_dqm, u8_push, u8_last, u8_busy}, e);
            end
        end
        u8_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_0); #1;
            col_valid_i = (c == 0);
            col_we_i    = 1'b1;
            col_full_i  = 1'b1;
            #1;
        end
        checks++;
        if (dq_en !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre dq_en/busy got %b%b expected 11", dq_en, busy_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o, err_o} !== 7'b0 || col_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_clear outs got %b ready %b expected 0000000 ready 1",
                     {tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o, err_o}, col_ready_o);
        end
        @(posedge clk_0); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_0); #2;
            checks++;
            if ({tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o} !== 6'b0) begin
                errors++;
                $display("FAIL midrst_trunc_c%0d got %b expected 000000", c,
                         {tx_pop_o, dq_en, dqm_en, rx_push_o, rx_last_o, busy_o});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d", errors);
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_write_single();
        test_read_single();
        test_back_to_back_write();
        test_back_to_back_read();
        test_turnaround();
        test_bl8_collision();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
